// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory request/response channel between an
// instruction-fetch port (I) and a data port (D). Only one bus transaction
// is ever in flight. D normally wins arbitration, but after two back-to-back
// D grants taken while I was waiting, I is given the next slot so fetch
// cannot starve. A redirect (i_cancel) while a fetch is in flight throws
// away that fetch's returning data.
module bus_arbiter (
  input  logic        clk,
  input  logic        reset,

  // instruction fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_cancel,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,

  // data port
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,

  // shared memory request channel
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,

  // shared memory response channel
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } state_t;

  state_t      state_q,    state_d;
  logic [1:0]  d_streak_q, d_streak_d;
  logic        cancel_q,   cancel_d;
  logic        d_wr_q,     d_wr_d;

  logic        grant_i;
  logic        grant_d;

  // Winner selection: D wins unless it has already taken two slots while I
  // was waiting, in which case I gets this one.
  always_comb begin
    grant_i = i_req & (~d_req | (d_streak_q == 2'd2));
    grant_d = d_req & ~grant_i;
  end

  // Request fields follow the current winner every cycle; nothing is latched,
  // so a stalled request can change until the bus accepts it.
  always_comb begin
    bus_wr    = 1'b0;
    bus_size  = 2'b00;
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;
    if (grant_i) begin
      bus_wr    = 1'b0;
      bus_size  = 2'b11;
      bus_addr  = i_addr;
      bus_wdata = 32'h0;
    end else if (grant_d) begin
      bus_wr    = d_wr;
      bus_size  = d_size;
      bus_addr  = d_addr;
      bus_wdata = d_wdata;
    end
  end

  // Next-state and handshake logic; reset forces all strobes and read data low.
  always_comb begin
    state_d    = state_q;
    d_streak_d = d_streak_q;
    cancel_d   = cancel_q;
    d_wr_d     = d_wr_q;
    bus_req    = 1'b0;
    i_addr_ok  = 1'b0;
    i_data_ok  = 1'b0;
    i_rdata    = 32'h0;
    d_addr_ok  = 1'b0;
    d_data_ok  = 1'b0;
    d_rdata    = 32'h0;

    case (state_q)
      IDLE: begin
        bus_req = i_req | d_req;
        if (bus_req && bus_addr_ok) begin
          if (grant_i) begin
            i_addr_ok  = 1'b1;
            state_d    = I_WAIT;
            d_streak_d = 2'd0;
            cancel_d   = i_cancel;
          end else begin
            d_addr_ok = 1'b1;
            state_d   = D_WAIT;
            d_wr_d    = d_wr;
            if (i_req && (d_streak_q < 2'd2)) begin
              d_streak_d = d_streak_q + 2'd1;
            end
          end
        end
      end

      I_WAIT: begin
        if (bus_data_ok) begin
          state_d  = IDLE;
          cancel_d = 1'b0;
          if (!(cancel_q || i_cancel)) begin
            i_data_ok = 1'b1;
            i_rdata   = bus_rdata;
          end
        end else if (i_cancel) begin
          cancel_d = 1'b1;
        end
      end

      D_WAIT: begin
        if (bus_data_ok) begin
          state_d   = IDLE;
          d_data_ok = 1'b1;
          d_rdata   = d_wr_q ? 32'h0 : bus_rdata;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (reset) begin
      bus_req   = 1'b0;
      i_addr_ok = 1'b0;
      i_data_ok = 1'b0;
      i_rdata   = 32'h0;
      d_addr_ok = 1'b0;
      d_data_ok = 1'b0;
      d_rdata   = 32'h0;
    end
  end

  // State registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      d_streak_q <= 2'd0;
      cancel_q   <= 1'b0;
      d_wr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_streak_q <= d_streak_d;
      cancel_q   <= cancel_d;
      d_wr_q     <= d_wr_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: cycle-by-cycle directed vectors for bus_arbiter. Each record
// holds one cycle's inputs and the outputs expected in that same cycle.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic        i_cancel = 1'b0;
  logic        i_addr_ok, i_data_ok;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [1:0]  d_size = 2'b00;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_addr_ok, d_data_ok;
  logic [31:0] d_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok = 1'b0;
  logic        bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_hand = 0;

  typedef struct packed {
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_cancel;
    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        e_breq;
    logic        e_bwr;
    logic [1:0]  e_bsize;
    logic [31:0] e_baddr;
    logic [31:0] e_bwdata;
    logic        e_iaok;
    logic        e_idok;
    logic [31:0] e_irdata;
    logic        e_daok;
    logic        e_ddok;
    logic [31:0] e_drdata;
  } vec_t;

  vec_t tbl[$];
  vec_t v;

  bus_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_cancel    (i_cancel),
    .i_addr_ok   (i_addr_ok),
    .i_data_ok   (i_data_ok),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_wr        (d_wr),
    .d_size      (d_size),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_addr_ok   (d_addr_ok),
    .d_data_ok   (d_data_ok),
    .d_rdata     (d_rdata),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_size    (bus_size),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  // Fresh vector: idle inputs, garbage on bus_rdata to expose leakage.
  task automatic nv();
    v = '0;
    v.rdata = 32'h5A5A_5A5A;
  endtask

  task automatic clr_exp();
    v.e_breq = 1'b0; v.e_bwr = 1'b0; v.e_bsize = 2'b00;
    v.e_baddr = 32'h0; v.e_bwdata = 32'h0;
    v.e_iaok = 1'b0; v.e_idok = 1'b0; v.e_irdata = 32'h0;
    v.e_daok = 1'b0; v.e_ddok = 1'b0; v.e_drdata = 32'h0;
    v.aok = 1'b0; v.dok = 1'b0; v.rdata = 32'h5A5A_5A5A;
  endtask

  task automatic req_i(input logic [31:0] a);
    v.i_req = 1'b1; v.i_addr = a;
  endtask

  task automatic req_d(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    v.d_req = 1'b1; v.d_wr = wr; v.d_size = sz; v.d_addr = a; v.d_wdata = wd;
  endtask

  task automatic exp_bus_i();
    v.e_breq = 1'b1; v.e_bwr = 1'b0; v.e_bsize = 2'b11;
    v.e_baddr = v.i_addr; v.e_bwdata = 32'h0;
  endtask

  task automatic exp_bus_d();
    v.e_breq = 1'b1; v.e_bwr = v.d_wr; v.e_bsize = v.d_size;
    v.e_baddr = v.d_addr; v.e_bwdata = v.d_wdata;
  endtask

  task automatic exp_idata(input logic [31:0] r);
    v.dok = 1'b1; v.rdata = r; v.e_idok = 1'b1; v.e_irdata = r;
  endtask

  task automatic exp_ddata(input logic [31:0] r);
    v.dok = 1'b1; v.rdata = r; v.e_ddok = 1'b1; v.e_drdata = r;
  endtask

  task automatic push();
    tbl.push_back(v);
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t s);
    reset       = s.rst;
    i_req       = s.i_req;
    i_addr      = s.i_addr;
    i_cancel    = s.i_cancel;
    d_req       = s.d_req;
    d_wr        = s.d_wr;
    d_size      = s.d_size;
    d_addr      = s.d_addr;
    d_wdata     = s.d_wdata;
    bus_addr_ok = s.aok;
    bus_data_ok = s.dok;
    bus_rdata   = s.rdata;
  endtask

  task automatic checkOutput(input vec_t s, input string tag);
    cmp({tag, " bus_req"},   {31'h0, bus_req},   {31'h0, s.e_breq});
    cmp({tag, " i_addr_ok"}, {31'h0, i_addr_ok}, {31'h0, s.e_iaok});
    cmp({tag, " i_data_ok"}, {31'h0, i_data_ok}, {31'h0, s.e_idok});
    cmp({tag, " i_rdata"},   i_rdata,            s.e_irdata);
    cmp({tag, " d_addr_ok"}, {31'h0, d_addr_ok}, {31'h0, s.e_daok});
    cmp({tag, " d_data_ok"}, {31'h0, d_data_ok}, {31'h0, s.e_ddok});
    cmp({tag, " d_rdata"},   d_rdata,            s.e_drdata);
    if (s.e_breq) begin
      cmp({tag, " bus_wr"},    {31'h0, bus_wr},    {31'h0, s.e_bwr});
      cmp({tag, " bus_size"},  {30'h0, bus_size},  {30'h0, s.e_bsize});
      cmp({tag, " bus_addr"},  bus_addr,           s.e_baddr);
      cmp({tag, " bus_wdata"}, bus_wdata,          s.e_bwdata);
    end
  endtask

  // One cycle: drive after the rising edge, sample at the falling edge.
  task automatic run_one(input vec_t s, input string tag);
    applyStimulus(s);
    @(negedge clk);
    checkOutput(s, tag);
    @(posedge clk);
    #1;
  endtask

  task automatic hand();
    run_one(v, $sformatf("h%0d", n_hand));
    n_hand++;
  endtask

  task automatic build_table();
    // reset dominates every input
    nv(); v.rst = 1'b1; req_i(32'hbfc0_0000); req_d(1'b0, 2'b10, 32'h1000, 32'h11);
    v.aok = 1'b1; v.dok = 1'b1; v.rdata = 32'hFFFF_0000; push();
    push();
    // single fetch: wait, handshake, wait state, data
    nv(); req_i(32'hbfc0_0000); exp_bus_i(); push();
    v.aok = 1'b1; v.e_iaok = 1'b1; push();
    nv(); v.aok = 1'b1; push();
    nv(); exp_idata(32'h2408_0001); push();
    // both requesting, bus stalls 3 cycles, D fields followed
    nv(); req_i(32'h0040_0000); req_d(1'b0, 2'b10, 32'h2000, 32'h77); exp_bus_d(); push();
    v.d_addr = 32'h2004; exp_bus_d(); push();
    v.d_addr = 32'h2008; v.d_wr = 1'b1; v.d_size = 2'b01; exp_bus_d(); push();
    // grant order D, D, I, D with a 1-cycle memory
    v.d_addr = 32'h200C; v.d_wr = 1'b0; v.d_size = 2'b10; v.aok = 1'b1; exp_bus_d(); v.e_daok = 1'b1; push();
    clr_exp(); v.aok = 1'b1; exp_ddata(32'h1111_0001); push();
    clr_exp(); v.d_addr = 32'h2010; v.aok = 1'b1; exp_bus_d(); v.e_daok = 1'b1; push();
    clr_exp(); exp_ddata(32'h1111_0002); push();
    clr_exp(); v.aok = 1'b1; exp_bus_i(); v.e_iaok = 1'b1; push();
    clr_exp(); exp_idata(32'h3C1D_0000); push();
    clr_exp(); v.d_addr = 32'h2014; v.aok = 1'b1; exp_bus_d(); v.e_daok = 1'b1; push();
    clr_exp(); exp_ddata(32'h1111_0004); push();
    // store: fields pass through, completion returns zero data
    nv(); req_d(1'b1, 2'b00, 32'h0000_0103, 32'h0000_00AA); v.aok = 1'b1; exp_bus_d(); v.e_daok = 1'b1; push();
    clr_exp(); v.dok = 1'b1; v.rdata = 32'h1234_5678; v.e_ddok = 1'b1; push();
    // bus_data_ok in IDLE ignored
    nv(); v.aok = 1'b1; v.dok = 1'b1; v.rdata = 32'hFFFF_FFFF; push();
    // data_ok coincident with addr_ok is not a completion
    nv(); req_d(1'b0, 2'b11, 32'h3000, 32'h0); v.aok = 1'b1; v.dok = 1'b1; v.rdata = 32'h99;
    exp_bus_d(); v.e_daok = 1'b1; push();
    nv(); v.i_cancel = 1'b1; push();
    nv(); exp_ddata(32'h0BAD_F00D); push();
    // streak: D with I waiting -> 2, D alone keeps 2, then I wins
    nv(); req_i(32'h0050_0000); req_d(1'b0, 2'b10, 32'h4000, 32'h0); v.aok = 1'b1; exp_bus_d(); v.e_daok = 1'b1; push();
    clr_exp(); exp_ddata(32'h44); push();
    nv(); req_d(1'b0, 2'b10, 32'h4004, 32'h0); v.aok = 1'b1; exp_bus_d(); v.e_daok = 1'b1; push();
    nv(); exp_ddata(32'h45); push();
    nv(); req_i(32'h0050_0000); req_d(1'b0, 2'b10, 32'h4008, 32'h0); exp_bus_i(); push();
    v.aok = 1'b1; v.e_iaok = 1'b1; push();
    clr_exp(); exp_idata(32'h46); push();
    clr_exp(); exp_bus_d(); push();
    // i_cancel in IDLE on a D handshake has no effect on the next fetch
    nv(); v.i_cancel = 1'b1; req_d(1'b0, 2'b10, 32'h5000, 32'h0); v.aok = 1'b1; exp_bus_d(); v.e_daok = 1'b1; push();
    nv(); exp_ddata(32'h51); push();
    nv(); req_i(32'h0060_0000); v.aok = 1'b1; exp_bus_i(); v.e_iaok = 1'b1; push();
    nv(); exp_idata(32'h61); push();
  endtask

  initial begin
    @(posedge clk);
    #1;
    build_table();
    for (int k = 0; k < tbl.size(); k++) begin
      run_one(tbl[k], $sformatf("v%0d", k));
    end

    // cancel pulsed in I_WAIT: returning data dropped, next fetch normal
    nv(); req_i(32'h0070_0000); v.aok = 1'b1; exp_bus_i(); v.e_iaok = 1'b1; hand();
    nv(); v.i_cancel = 1'b1; hand();
    nv(); v.dok = 1'b1; v.rdata = 32'hDEAD_BEEF; hand();
    nv(); req_i(32'h0070_0004); v.aok = 1'b1; exp_bus_i(); v.e_iaok = 1'b1; hand();
    nv(); exp_idata(32'hCAFE_F00D); hand();
    // cancel coincident with the I handshake
    nv(); req_i(32'h0070_0008); v.i_cancel = 1'b1; v.aok = 1'b1; exp_bus_i(); v.e_iaok = 1'b1; hand();
    nv(); hand();
    nv(); v.dok = 1'b1; v.rdata = 32'h0000_1234; hand();
    // cancel in the same cycle as data_ok
    nv(); req_i(32'h0070_000C); v.aok = 1'b1; exp_bus_i(); v.e_iaok = 1'b1; hand();
    nv(); v.i_cancel = 1'b1; v.dok = 1'b1; v.rdata = 32'h77; hand();
    nv(); req_i(32'h0070_0010); v.aok = 1'b1; exp_bus_i(); v.e_iaok = 1'b1; hand();
    nv(); exp_idata(32'h0000_7010); hand();
    // reset in D_WAIT, late data_ok ignored, next D normal
    nv(); req_d(1'b0, 2'b10, 32'h8000, 32'h0); v.aok = 1'b1; exp_bus_d(); v.e_daok = 1'b1; hand();
    nv(); v.rst = 1'b1; hand();
    nv(); v.dok = 1'b1; v.rdata = 32'h88; hand();
    nv(); req_d(1'b0, 2'b10, 32'h8004, 32'h0); v.aok = 1'b1; exp_bus_d(); v.e_daok = 1'b1; hand();
    nv(); exp_ddata(32'h89); hand();
    // reset clears a pending cancel
    nv(); req_i(32'h0090_0000); v.aok = 1'b1; exp_bus_i(); v.e_iaok = 1'b1; hand();
    nv(); v.i_cancel = 1'b1; hand();
    nv(); v.rst = 1'b1; hand();
    nv(); req_i(32'h0090_0004); v.aok = 1'b1; exp_bus_i(); v.e_iaok = 1'b1; hand();
    nv(); exp_idata(32'h9A9A_0004); hand();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk and reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 i_req  in  1  fetch request; i_addr  in  32  fetch address.
REQ-005 i_cancel  in  1  redirect (branch/jump/interrupt); discard the pending fetch.
REQ-006 i_addr_ok  out  1  fetch address accepted; i_data_ok  out  1  fetch data valid; i_rdata  out  32  fetch data.
REQ-007 d_req  in  1  data request; d_wr  in  1  1 = store; d_size  in  2  byte count minus 1; d_addr  in  32  data address; d_wdata  in  32  store data.
REQ-008 d_addr_ok  out  1  data address accepted; d_data_ok  out  1  load data valid or store done; d_rdata  out  32  load data.
REQ-009 bus_req  out  1; bus_wr  out  1; bus_size  out  2; bus_addr  out  32; bus_wdata  out  32  shared memory request channel.
REQ-010 bus_addr_ok  in  1; bus_data_ok  in  1; bus_rdata  in  32  shared memory response channel.

Function
REQ-011 The FSM SHALL have three states: IDLE, I_WAIT and D_WAIT; at most one bus transaction SHALL be outstanding.
REQ-012 In IDLE, bus_req SHALL equal i_req|d_req, and bus_wr/size/addr/wdata SHALL be driven combinationally from the winner; for an I grant, bus_wr=0, bus_size=2'b11 and bus_wdata=0.
REQ-013 Winner selection: d_req wins, except when d_streak==2 and i_req=1, in which case I wins.
REQ-014 d_streak (2-bit) SHALL increment, saturating at 2, on each D handshake while i_req=1, and SHALL clear on any I handshake.
REQ-015 A handshake is bus_req & bus_addr_ok in IDLE: assert the winner's addr_ok only, in the same cycle; next state is I_WAIT or D_WAIT.
REQ-016 Without bus_addr_ok, the winner SHALL be re-evaluated each cycle; request fields SHALL not be latched.
REQ-017 In I_WAIT or D_WAIT, bus_req, i_addr_ok and d_addr_ok SHALL be 0.
REQ-018 On bus_data_ok in D_WAIT: d_data_ok=1, d_rdata=bus_rdata for loads and 0 for stores, same cycle; next state IDLE.
REQ-019 On bus_data_ok in I_WAIT with cancel_flag=0: i_data_ok=1, i_rdata=bus_rdata, same cycle; next state IDLE.
REQ-020 cancel_flag SHALL set on i_cancel in I_WAIT, or on i_cancel coincident with an I handshake.
REQ-021 When cancel_flag or i_cancel is set at bus_data_ok in I_WAIT, i_data_ok SHALL stay 0, the next state SHALL be IDLE, and cancel_flag SHALL clear.
REQ-022 i_cancel in IDLE without an I handshake, or in D_WAIT, SHALL have no effect.
REQ-023 bus_data_ok in IDLE SHALL be ignored, and both data_ok outputs SHALL stay 0.
REQ-024 i_rdata and d_rdata SHALL be 0 whenever their data_ok is 0.
REQ-025 Minimum latency: addr_ok in cycle N, data_ok no earlier than cycle N+1, next handshake no earlier than that data_ok cycle +1.

Reset
REQ-026 While reset=1: bus_req, all addr_ok/data_ok and all rdata outputs SHALL be 0, regardless of inputs.
REQ-027 After a reset cycle: state=IDLE, d_streak=0, cancel_flag=0.
REQ-028 Reset mid-transaction SHALL abandon the transaction; a late bus_data_ok SHALL be ignored under REQ-023.

Verification
REQ-029 i_req=1, i_addr=32'hbfc0_0000, addr_ok at cycle 1, data_ok at cycle 3 with rdata=32'h2408_0001 -> i_addr_ok@1, i_data_ok@3, i_rdata=32'h2408_0001, bus_req=0@2-3.
REQ-030 i_req and d_req both held for 4 transactions, 1-cycle memory -> grant order D, D, I, D; d_streak trace 1, 2, 0, 1.
REQ-031 I fetch outstanding, i_cancel pulsed in I_WAIT, data_ok returns 32'hDEAD_BEEF -> i_data_ok=0, i_rdata=0, back to IDLE, next i_req granted normally.
REQ-032 Store: d_wr=1, d_size=2'b00, d_addr=32'h0000_0103, d_wdata=32'h0000_00AA -> bus fields match; d_data_ok=1, d_rdata=0.
REQ-033 reset asserted in D_WAIT, then bus_data_ok after reset released -> d_data_ok=0, state IDLE, next d_req handshakes normally.
REQ-034 bus_addr_ok=0 for 3 cycles with d_req=1 and i_req=1 -> no addr_ok asserted; bus_addr follows the D request until granted.
